// File: rtl/slave_bit_timer.sv
// slave_bit_timer: START/STOP detection and per-bit strobes for a 9-clock I2C byte frame; no backpressure.
// Latency 2 clk from line change, 2+FILTER_LEN when SLAVE_TIMER_FILTER_EN is defined.
module slave_bit_timer #(
   parameter int FILTER_LEN = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       SCL_sync,
   input  logic       SDA_sync,
   output logic       start,
   output logic       stop,
   output logic       byte_received,
   output logic       ack_prep,
   output logic       ack_check,
   output logic       ack_done,
   output logic       shift_rx,
   output logic       shift_tx,
   output logic [3:0] bit_count,
   output logic       bus_active
);

   typedef enum logic [1:0] {IDLE, WAIT_FALL, DATA, ACK} state_t;

   state_t state;
   logic   scl_lvl, sda_lvl;
   logic   scl_q, scl_qq, sda_q, sda_qq;
   logic   scl_rise, scl_fall, start_ev, stop_ev;

`ifdef SLAVE_TIMER_FILTER_EN
   localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);

   logic [3:0] scl_cnt, sda_cnt;

   // A new level is accepted only after FILTER_LEN consecutive samples disagree with the current one.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_lvl <= 1'b1;
         sda_lvl <= 1'b1;
         scl_cnt <= '0;
         sda_cnt <= '0;
      end else begin
         if (SCL_sync == scl_lvl) begin
            scl_cnt <= '0;
         end else if (scl_cnt == FILT_LAST) begin
            scl_lvl <= SCL_sync;
            scl_cnt <= '0;
         end else begin
            scl_cnt <= scl_cnt + 4'd1;
         end
         if (SDA_sync == sda_lvl) begin
            sda_cnt <= '0;
         end else if (sda_cnt == FILT_LAST) begin
            sda_lvl <= SDA_sync;
            sda_cnt <= '0;
         end else begin
            sda_cnt <= sda_cnt + 4'd1;
         end
      end
   end
`else
   logic [3:0] unused_filter_len;
   assign unused_filter_len = 4'(FILTER_LEN);
   assign scl_lvl = SCL_sync;
   assign sda_lvl = SDA_sync;
`endif

   assign scl_rise = scl_q & ~scl_qq;
   assign scl_fall = ~scl_q & scl_qq;
   assign start_ev = scl_q & scl_qq & ~sda_q & sda_qq;
   assign stop_ev  = scl_q & scl_qq & sda_q & ~sda_qq;

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_q         <= 1'b1;
         scl_qq        <= 1'b1;
         sda_q         <= 1'b1;
         sda_qq        <= 1'b1;
         state         <= IDLE;
         bit_count     <= '0;
         bus_active    <= 1'b0;
         start         <= 1'b0;
         stop          <= 1'b0;
         byte_received <= 1'b0;
         ack_prep      <= 1'b0;
         ack_check     <= 1'b0;
         ack_done      <= 1'b0;
         shift_rx      <= 1'b0;
         shift_tx      <= 1'b0;
      end else begin
         scl_q         <= scl_lvl;
         scl_qq        <= scl_q;
         sda_q         <= sda_lvl;
         sda_qq        <= sda_q;
         start         <= 1'b0;
         stop          <= 1'b0;
         byte_received <= 1'b0;
         ack_prep      <= 1'b0;
         ack_check     <= 1'b0;
         ack_done      <= 1'b0;
         shift_rx      <= 1'b0;
         shift_tx      <= 1'b0;
         // Bus conditions override any SCL strobe in the same cycle, from every state.
         if (start_ev) begin
            start      <= 1'b1;
            bit_count  <= '0;
            bus_active <= 1'b1;
            state      <= WAIT_FALL;
         end else if (stop_ev) begin
            stop       <= 1'b1;
            bit_count  <= '0;
            bus_active <= 1'b0;
            state      <= IDLE;
         end else begin
            case (state)
               IDLE: begin
               end
               WAIT_FALL: begin
                  if (scl_fall) begin
                     bit_count <= '0;
                     state     <= DATA;
                  end
               end
               DATA: begin
                  if (scl_rise && bit_count < 4'd8) begin
                     bit_count     <= bit_count + 4'd1;
                     shift_rx      <= 1'b1;
                     byte_received <= (bit_count == 4'd7);
                  end else if (scl_fall) begin
                     if (bit_count == 4'd8) begin
                        ack_prep <= 1'b1;
                        state    <= ACK;
                     end else if (bit_count != 4'd0) begin
                        shift_tx <= 1'b1;
                     end
                  end
               end
               ACK: begin
                  if (scl_rise && bit_count == 4'd8) begin
                     bit_count <= 4'd9;
                     ack_check <= 1'b1;
                  end else if (scl_fall && bit_count == 4'd9) begin
                     bit_count <= '0;
                     ack_done  <= 1'b1;
                     state     <= DATA;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
